ex_stage_pipe: RTL

//  Parametrised execute stage: ALU, branch resolve, optional iterative mul/div (HI/LO), registered EX/MEM beat.

---
 rtl/ex_stage_pipe.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/ex_stage_pipe.sv
// ex_stage_pipe: execute stage between ID/EX and MEM.
// ALU, branch resolve, registered EX/MEM beat with valid/ready on both sides.
// Define EX_MULDIV_EN to build the radix-2 iterative mul/div unit with HI/LO;
// without it, ops 0x10..0x15 are single-cycle illegal ops.
module ex_stage_pipe #(
  parameter int DATA_W  = 32,
  parameter int RADDR_W = 5,
  parameter int CTRL_W  = 8
) (
  input  logic               clk,
  input  logic               rst_b,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  rs_data,
  input  logic [DATA_W-1:0]  rt_data,
  input  logic [DATA_W-1:0]  imm_ext,
  input  logic [DATA_W-1:0]  pc4,
  input  logic [4:0]         shamt,
  input  logic [RADDR_W-1:0] rt_num,
  input  logic [RADDR_W-1:0] rd_num,
  input  logic [1:0]         dest_sel,
  input  logic               alu_src,
  input  logic [4:0]         alu_op,
  input  logic               branch,
  input  logic               flush,
  input  logic [CTRL_W-1:0]  ctrl_in,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  alu_result,
  output logic [DATA_W-1:0]  rt_data_out,
  output logic [RADDR_W-1:0] wr_num,
  output logic               pc_src,
  output logic [DATA_W-1:0]  baddr,
  output logic               busy,
  output logic               ill_op
);

  localparam logic [4:0] OP_ADD  = 5'h00, OP_SUB  = 5'h01, OP_AND = 5'h02, OP_OR  = 5'h03;
  localparam logic [4:0] OP_XOR  = 5'h04, OP_NOR  = 5'h05, OP_SLT = 5'h06, OP_SLTU = 5'h07;
  localparam logic [4:0] OP_SLL  = 5'h08, OP_SRL  = 5'h09, OP_SRA = 5'h0A, OP_LUI = 5'h0B;

  typedef enum logic [1:0] {S_IDLE, S_MULDIV, S_DONE} state_t;

  state_t              r_state, w_nstate;
  logic                r_out_valid, r_pcs, r_ill;
  logic [DATA_W-1:0]   r_res, r_rtd, r_baddr;
  logic [RADDR_W-1:0]  r_wr;
  logic [CTRL_W-1:0]   r_ctrl;

  logic [DATA_W-1:0]   w_b, w_diff, w_res;
  logic [RADDR_W-1:0]  w_wr;
  logic                w_zero, w_ill, w_out_free, w_acc, w_is_md;

`ifdef EX_MULDIV_EN
  localparam logic [4:0] OP_MULT = 5'h10, OP_MULTU = 5'h11, OP_DIV = 5'h12, OP_DIVU = 5'h13;
  localparam logic [4:0] OP_MFHI = 5'h14, OP_MFLO  = 5'h15;
  localparam int CNT_W = $clog2(DATA_W);

  logic [DATA_W-1:0]   r_hi, r_lo, r_wa, r_wb, r_dvs, r_dvd;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_div, r_negq, r_negr, r_dz;
  logic                w_sgn, w_done_fire;
  logic [DATA_W-1:0]   w_ma, w_mb, w_nwa, w_nwb, w_q, w_r, w_hi_fin, w_lo_fin;
  logic [DATA_W:0]     w_msum, w_sh, w_trial;
  logic [2*DATA_W-1:0] w_prod, w_prod_f;
`endif

  assign w_b        = alu_src ? imm_ext : rt_data;
  assign w_diff     = rs_data - w_b;
  assign w_zero     = (w_diff == '0);
  assign w_out_free = !r_out_valid || out_ready;
  assign in_ready   = (r_state == S_IDLE) && w_out_free;
  // a beat presented while flush is high is dropped
  assign w_acc      = in_valid && in_ready && !flush;

  // single-cycle ALU result and illegal-op decode
  always_comb begin
    w_res = '0;
    w_ill = 1'b0;
    case (alu_op)
      OP_ADD:  w_res = rs_data + w_b;
      OP_SUB:  w_res = w_diff;
      OP_AND:  w_res = rs_data & w_b;
      OP_OR:   w_res = rs_data | w_b;
      OP_XOR:  w_res = rs_data ^ w_b;
      OP_NOR:  w_res = ~(rs_data | w_b);
      OP_SLT:  w_res = {{(DATA_W-1){1'b0}}, $signed(rs_data) < $signed(w_b)};
      OP_SLTU: w_res = {{(DATA_W-1){1'b0}}, rs_data < w_b};
      OP_SLL:  w_res = w_b << shamt;
      OP_SRL:  w_res = w_b >> shamt;
      OP_SRA:  w_res = $signed(w_b) >>> shamt;
      OP_LUI:  w_res = w_b << 16;
`ifdef EX_MULDIV_EN
      OP_MFHI: w_res = r_hi;
      OP_MFLO: w_res = r_lo;
      // mul/div result is delivered later from the DONE state
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: w_res = '0;
`endif
      default: w_ill = 1'b1;
    endcase
  end

  // destination register select
  always_comb begin
    case (dest_sel)
      2'b01:   w_wr = rd_num;
      2'b10:   w_wr = '1;
      default: w_wr = rt_num;
    endcase
  end

`ifdef EX_MULDIV_EN
  assign w_is_md     = (alu_op >= OP_MULT) && (alu_op <= OP_DIVU);
  assign w_sgn       = (alu_op == OP_MULT) || (alu_op == OP_DIV);
  assign w_ma        = (w_sgn && rs_data[DATA_W-1]) ? -rs_data : rs_data;
  assign w_mb        = (w_sgn && w_b[DATA_W-1]) ? -w_b : w_b;
  assign w_done_fire = (r_state == S_DONE) && w_out_free && !flush;

  // one iteration of shift-add multiply or restoring divide on magnitudes
  always_comb begin
    w_msum  = {1'b0, r_wa} + (r_wb[0] ? {1'b0, r_dvs} : '0);
    w_sh    = {r_wa, r_wb[DATA_W-1]};
    w_trial = w_sh - {1'b0, r_dvs};
    if (!r_div) begin
      w_nwa = w_msum[DATA_W:1];
      w_nwb = {w_msum[0], r_wb[DATA_W-1:1]};
    end else if (!w_trial[DATA_W]) begin
      w_nwa = w_trial[DATA_W-1:0];
      w_nwb = {r_wb[DATA_W-2:0], 1'b1};
    end else begin
      w_nwa = w_sh[DATA_W-1:0];
      w_nwb = {r_wb[DATA_W-2:0], 1'b0};
    end
  end

  // sign fix-up and divide-by-zero override at completion
  always_comb begin
    w_prod   = {r_wa, r_wb};
    w_prod_f = r_negq ? -w_prod : w_prod;
    w_q      = r_negq ? -r_wb : r_wb;
    w_r      = r_negr ? -r_wa : r_wa;
    if (!r_div) begin
      w_hi_fin = w_prod_f[2*DATA_W-1:DATA_W];
      w_lo_fin = w_prod_f[DATA_W-1:0];
    end else if (r_dz) begin
      w_hi_fin = r_dvd;
      w_lo_fin = '1;
    end else begin
      w_hi_fin = w_r;
      w_lo_fin = w_q;
    end
  end

  // mul/div working registers and architectural HI/LO
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_hi <= '0; r_lo <= '0; r_wa <= '0; r_wb <= '0; r_dvs <= '0; r_dvd <= '0;
      r_cnt <= '0; r_div <= 1'b0; r_negq <= 1'b0; r_negr <= 1'b0; r_dz <= 1'b0;
    end else if (!flush) begin
      if (w_acc && w_is_md) begin
        r_wa   <= '0;
        r_wb   <= w_ma;
        r_dvs  <= w_mb;
        r_dvd  <= rs_data;
        r_cnt  <= CNT_W'(DATA_W-1);
        r_div  <= alu_op[1];
        r_negq <= w_sgn && (rs_data[DATA_W-1] ^ w_b[DATA_W-1]);
        r_negr <= w_sgn && rs_data[DATA_W-1];
        r_dz   <= (w_b == '0);
      end else if (r_state == S_MULDIV) begin
        r_wa  <= w_nwa;
        r_wb  <= w_nwb;
        r_cnt <= r_cnt - 1'b1;
      end else if (w_done_fire) begin
        r_hi <= w_hi_fin;
        r_lo <= w_lo_fin;
      end
    end
  end
`else
  assign w_is_md = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= S_IDLE;
    else        r_state <= w_nstate;
  end

  // FSM next state; flush aborts any iteration
  always_comb begin
    w_nstate = r_state;
`ifdef EX_MULDIV_EN
    if (flush) w_nstate = S_IDLE;
    else begin
      case (r_state)
        S_IDLE:   if (w_acc && w_is_md) w_nstate = S_MULDIV;
        S_MULDIV: if (r_cnt == '0)      w_nstate = S_DONE;
        S_DONE:   if (w_out_free)       w_nstate = S_IDLE;
        default:  w_nstate = S_IDLE;
      endcase
    end
`else
    w_nstate = S_IDLE;
`endif
  end

  // FSM outputs
  always_comb begin
    busy = (r_state == S_MULDIV);
  end

  // EX/MEM output beat; held while the consumer stalls
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_out_valid <= 1'b0; r_res <= '0; r_rtd <= '0; r_baddr <= '0;
      r_wr <= '0; r_ctrl <= '0; r_pcs <= 1'b0; r_ill <= 1'b0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
    end else if (w_acc) begin
      r_rtd       <= rt_data;
      r_wr        <= w_wr;
      r_ctrl      <= ctrl_in;
      r_pcs       <= branch && w_zero;
      r_baddr     <= pc4 + (imm_ext << 2);
      r_ill       <= w_ill;
      r_out_valid <= !w_is_md;
      if (!w_is_md) r_res <= w_res;
`ifdef EX_MULDIV_EN
    end else if (w_done_fire) begin
      r_res       <= w_lo_fin;
      r_out_valid <= 1'b1;
`endif
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid   = r_out_valid;
  assign alu_result  = r_res;
  assign rt_data_out = r_rtd;
  assign wr_num      = r_wr;
  assign ctrl_out    = r_ctrl;
  assign pc_src      = r_pcs;
  assign baddr       = r_baddr;
  assign ill_op      = r_ill;

endmodule
